// File: rtl/axi_imem_slave.sv
// AXI4 read-only instruction memory with a regbus load/readback window.
// Ports: ACLK/ARESET, regbus WR*/RD*, AXI AR channel S_AR*, R channel S_R*.
module axi_imem_slave #(
  parameter logic [31:0] MEM_BASE    = 32'h2000_0000,
  parameter int          DEPTH_WORDS = 1024,
  parameter logic [15:0] REG_BASE    = 16'h4000,
  parameter int          ID_W        = 4
) (
  input  logic            ACLK,
  input  logic            ARESET,
  input  logic [15:0]     WRADDR,
  input  logic [3:0]      BYTEEN,
  input  logic            WREN,
  input  logic [31:0]     WDATA,
  input  logic [15:0]     RDADDR,
  input  logic            RDEN,
  output logic [31:0]     RDATA,
  input  logic [ID_W-1:0] S_ARID,
  input  logic [31:0]     S_ARADDR,
  input  logic [7:0]      S_ARLEN,
  input  logic [2:0]      S_ARSIZE,
  input  logic [1:0]      S_ARBURST,
  input  logic            S_ARVALID,
  output logic            S_ARREADY,
  output logic [ID_W-1:0] S_RID,
  output logic [31:0]     S_RDATA,
  output logic [1:0]      S_RRESP,
  output logic            S_RLAST,
  output logic            S_RVALID,
  input  logic            S_RREADY
);

  localparam int AW = $clog2(DEPTH_WORDS);

  typedef enum logic [1:0] {
    IDLE,
    BURST,
    DRAIN
  } state_t;

  logic [31:0] mem [DEPTH_WORDS];

  state_t          state;
  logic            arready_q;
  logic [ID_W-1:0] id_q;
  logic [29:0]     wa_q;
  logic [7:0]      fcnt_q;
  logic [1:0]      burst_q;
  logic [3:0]      wmask_q;
  logic            slverr_q;
  logic            fetching_q;
  logic [31:0]     rdata_q;

  // Two-entry response buffer; memory data lands directly in it.
  logic [31:0] fd [2];
  logic [1:0]  fr [2];
  logic        fl [2];
  logic        wp;
  logic        rp;
  logic [1:0]  cnt;

  logic [15:0]   wr_off;
  logic [15:0]   rd_off;
  logic          wr_hit;
  logic          rd_hit;
  logic [AW-1:0] wr_idx;
  logic [AW-1:0] rd_idx_reg;
  logic [29:0]   off_w;
  logic          in_rng;
  logic [AW-1:0] axi_idx;
  logic [AW-1:0] rd_idx;
  logic [31:0]   mem_rd;
  logic          pop;
  logic          fetch;
  logic [1:0]    beat_resp;
  logic [31:0]   beat_data;
  logic [29:0]   wa_inc;
  logic [29:0]   wa_nxt;
  logic [29:0]   wmask_w;
  logic          arlen_wrap_ok;
  logic          unused_bits;

  assign wr_off     = WRADDR - REG_BASE;
  assign rd_off     = RDADDR - REG_BASE;
  assign wr_hit     = (wr_off >> (AW + 2)) == 16'd0;
  assign rd_hit     = (rd_off >> (AW + 2)) == 16'd0;
  assign wr_idx     = wr_off[AW+1:2];
  assign rd_idx_reg = rd_off[AW+1:2];

  assign off_w   = wa_q - MEM_BASE[31:2];
  assign in_rng  = (off_w >> AW) == 30'd0;
  assign axi_idx = off_w[AW-1:0];

  // Single read port: a regbus read steals it for the cycle.
  assign rd_idx = RDEN ? rd_idx_reg : axi_idx;
  assign mem_rd = mem[rd_idx];

  assign S_RVALID  = cnt != 2'd0;
  assign S_RDATA   = fd[rp];
  assign S_RRESP   = fr[rp];
  assign S_RLAST   = fl[rp];
  assign S_RID     = id_q;
  assign S_ARREADY = arready_q;
  assign RDATA     = rdata_q;

  assign pop   = S_RVALID && S_RREADY;
  assign fetch = (state == BURST) && fetching_q && !RDEN &&
                 ((cnt != 2'd2) || pop);

  always_comb begin
    beat_resp = 2'b00;
    beat_data = mem_rd;
    if (slverr_q) begin
      beat_resp = 2'b10;
      beat_data = 32'h0;
    end else if (!in_rng) begin
      beat_resp = 2'b11;
      beat_data = 32'h0;
    end
  end

  assign wa_inc  = wa_q + 30'd1;
  assign wmask_w = {26'd0, wmask_q};

  always_comb begin
    wa_nxt = wa_q;
    case (burst_q)
      2'b01:   wa_nxt = wa_inc;
      2'b10:   wa_nxt = (wa_q & ~wmask_w) | (wa_inc & wmask_w);
      default: wa_nxt = wa_q;
    endcase
  end

  assign arlen_wrap_ok = (S_ARLEN == 8'd1) || (S_ARLEN == 8'd3) ||
                         (S_ARLEN == 8'd7) || (S_ARLEN == 8'd15);

  assign unused_bits = ^{S_ARADDR[1:0], wr_off[1:0], rd_off[1:0]};

  always_ff @(posedge ACLK) begin
    if (WREN && wr_hit) begin
      for (int i = 0; i < 4; i++) begin
        if (BYTEEN[i]) mem[wr_idx][8*i +: 8] <= WDATA[8*i +: 8];
      end
    end
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      rdata_q <= 32'h0;
    end else if (RDEN) begin
      rdata_q <= rd_hit ? mem_rd : 32'h0;
    end
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      for (int i = 0; i < 2; i++) begin
        fd[i] <= 32'h0;
        fr[i] <= 2'b00;
        fl[i] <= 1'b0;
      end
      wp  <= 1'b0;
      rp  <= 1'b0;
      cnt <= 2'd0;
    end else begin
      if (fetch) begin
        fd[wp] <= beat_data;
        fr[wp] <= beat_resp;
        fl[wp] <= fcnt_q == 8'd0;
        wp     <= ~wp;
      end
      if (pop) rp <= ~rp;
      cnt <= cnt + {1'b0, fetch} - {1'b0, pop};
    end
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state      <= IDLE;
      arready_q  <= 1'b0;
      id_q       <= '0;
      wa_q       <= 30'd0;
      fcnt_q     <= 8'd0;
      burst_q    <= 2'b00;
      wmask_q    <= 4'd0;
      slverr_q   <= 1'b0;
      fetching_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (S_ARVALID && arready_q) begin
            id_q       <= S_ARID;
            wa_q       <= S_ARADDR[31:2];
            fcnt_q     <= S_ARLEN;
            burst_q    <= S_ARBURST;
            wmask_q    <= S_ARLEN[3:0];
            slverr_q   <= (S_ARSIZE != 3'b010) ||
                          (S_ARBURST == 2'b11) ||
                          ((S_ARBURST == 2'b10) && !arlen_wrap_ok);
            fetching_q <= 1'b1;
            arready_q  <= 1'b0;
            state      <= BURST;
          end else begin
            arready_q <= 1'b1;
          end
        end
        BURST: begin
          if (fetch) begin
            if (fcnt_q == 8'd0) fetching_q <= 1'b0;
            else fcnt_q <= fcnt_q - 8'd1;
            wa_q <= wa_nxt;
          end
          if (pop && fl[rp]) state <= DRAIN;
        end
        DRAIN: begin
          state     <= IDLE;
          arready_q <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_imem_slave.sv
// Directed bench for axi_imem_slave: regbus load/readback and AXI bursts.
// Checks use immediate assertions; one summary line at the end.
module tb_axi_imem_slave;

  logic        ACLK = 1'b0;
  logic        ARESET = 1'b1;
  logic [15:0] WRADDR = '0;
  logic [3:0]  BYTEEN = '0;
  logic        WREN = 1'b0;
  logic [31:0] WDATA = '0;
  logic [15:0] RDADDR = '0;
  logic        RDEN = 1'b0;
  logic [31:0] RDATA;
  logic [3:0]  S_ARID = '0;
  logic [31:0] S_ARADDR = '0;
  logic [7:0]  S_ARLEN = '0;
  logic [2:0]  S_ARSIZE = 3'b010;
  logic [1:0]  S_ARBURST = 2'b01;
  logic        S_ARVALID = 1'b0;
  logic        S_ARREADY;
  logic [3:0]  S_RID;
  logic [31:0] S_RDATA;
  logic [1:0]  S_RRESP;
  logic        S_RLAST;
  logic        S_RVALID;
  logic        S_RREADY = 1'b1;

  int passes = 0;
  int total = 0;
  logic [3:0] exp_id = '0;

  localparam logic [31:0] MB = 32'h2000_0000;

  axi_imem_slave dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .WRADDR(WRADDR), .BYTEEN(BYTEEN), .WREN(WREN), .WDATA(WDATA),
    .RDADDR(RDADDR), .RDEN(RDEN), .RDATA(RDATA),
    .S_ARID(S_ARID), .S_ARADDR(S_ARADDR), .S_ARLEN(S_ARLEN),
    .S_ARSIZE(S_ARSIZE), .S_ARBURST(S_ARBURST),
    .S_ARVALID(S_ARVALID), .S_ARREADY(S_ARREADY),
    .S_RID(S_RID), .S_RDATA(S_RDATA), .S_RRESP(S_RRESP),
    .S_RLAST(S_RLAST), .S_RVALID(S_RVALID), .S_RREADY(S_RREADY)
  );

  always #5 ACLK = ~ACLK;

  task automatic tick();
    @(posedge ACLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  task automatic timeout(input string tag);
    total++;
    $error("FAIL %s: got timeout expected event", tag);
  endtask

  task automatic regwr(input logic [15:0] a, input logic [3:0] be,
                       input logic [31:0] d);
    WRADDR = a; BYTEEN = be; WDATA = d; WREN = 1'b1;
    tick();
    WREN = 1'b0;
  endtask

  task automatic regrd(input string tag, input logic [15:0] a,
                       input logic [31:0] exp);
    RDADDR = a; RDEN = 1'b1;
    tick();
    RDEN = 1'b0;
    chk(tag, RDATA, exp);
  endtask

  // Returns in the cycle right after the AR handshake cycle.
  task automatic ar(input logic [3:0] id, input logic [31:0] a,
                    input logic [7:0] len, input logic [2:0] sz,
                    input logic [1:0] bt);
    int n = 0;
    while (!S_ARREADY && n < 20) begin
      tick();
      n++;
    end
    if (!S_ARREADY) timeout("ar_wait");
    S_ARID = id; S_ARADDR = a; S_ARLEN = len;
    S_ARSIZE = sz; S_ARBURST = bt; S_ARVALID = 1'b1;
    exp_id = id;
    tick();
    S_ARVALID = 1'b0;
  endtask

  task automatic beat(input string tag, input logic [31:0] d,
                      input logic [1:0] r, input logic l);
    int n = 0;
    while (!S_RVALID && n < 20) begin
      tick();
      n++;
    end
    if (!S_RVALID) begin
      timeout(tag);
    end else begin
      chk({tag, "_data"}, S_RDATA, d);
      chk({tag, "_resp"}, {30'd0, S_RRESP}, {30'd0, r});
      chk({tag, "_last"}, {31'd0, S_RLAST}, {31'd0, l});
      chk({tag, "_id"}, {28'd0, S_RID}, {28'd0, exp_id});
      tick();
    end
  endtask

  initial begin
    int idx;
    int cyc;
    logic rr;

    // Reset state
    tick();
    tick();
    chk("rst_arready", {31'd0, S_ARREADY}, 32'd0);
    chk("rst_rvalid", {31'd0, S_RVALID}, 32'd0);
    chk("rst_rlast", {31'd0, S_RLAST}, 32'd0);
    chk("rst_rresp", {30'd0, S_RRESP}, 32'd0);
    chk("rst_rdata", S_RDATA, 32'd0);
    chk("rst_rid", {28'd0, S_RID}, 32'd0);
    chk("rst_regrdata", RDATA, 32'd0);
    ARESET = 1'b0;
    tick();
    chk("idle_arready", {31'd0, S_ARREADY}, 32'd1);

    // Byte-enable merge and read latency
    regwr(16'h4000, 4'hF, 32'hDEAD_BEEF);
    regwr(16'h4000, 4'b0010, 32'h0000_1100);
    regrd("reg_merge", 16'h4000, 32'hDEAD_11EF);
    tick();
    chk("reg_hold", RDATA, 32'hDEAD_11EF);
    regwr(16'h5000, 4'hF, 32'h1234_5678);
    regrd("reg_miss_rd", 16'h5000, 32'h0);
    regrd("reg_miss_wr", 16'h4000, 32'hDEAD_11EF);

    // Load words 0..15
    for (int i = 0; i < 16; i++)
      regwr(16'h4000 + 16'(4 * i), 4'hF, 32'h100 + 32'(i));
    regwr(16'h4FFC, 4'hF, 32'hCAFE_F00D);

    // INCR LEN=7: latency and back-to-back beats
    S_RREADY = 1'b1;
    ar(4'd3, MB, 8'd7, 3'b010, 2'b01);
    chk("incr_lat1", {31'd0, S_RVALID}, 32'd0);
    tick();
    chk("incr_lat2", {31'd0, S_RVALID}, 32'd1);
    for (int i = 0; i < 8; i++) begin
      chk("incr_consec", {31'd0, S_RVALID}, 32'd1);
      beat("incr", 32'h100 + 32'(i), 2'b00, i == 7);
    end
    chk("incr_done", {31'd0, S_RVALID}, 32'd0);
    chk("drain_arready", {31'd0, S_ARREADY}, 32'd0);
    tick();
    chk("post_arready", {31'd0, S_ARREADY}, 32'd1);

    // WRAP LEN=3 from word 2
    ar(4'd1, MB + 32'h8, 8'd3, 3'b010, 2'b10);
    beat("wrap0", 32'h102, 2'b00, 1'b0);
    beat("wrap1", 32'h103, 2'b00, 1'b0);
    beat("wrap2", 32'h100, 2'b00, 1'b0);
    beat("wrap3", 32'h101, 2'b00, 1'b1);

    // FIXED LEN=2 at word 1
    ar(4'd2, MB + 32'h4, 8'd2, 3'b010, 2'b00);
    beat("fix0", 32'h101, 2'b00, 1'b0);
    beat("fix1", 32'h101, 2'b00, 1'b0);
    beat("fix2", 32'h101, 2'b00, 1'b1);

    // Bad size -> SLVERR
    ar(4'd4, MB, 8'd1, 3'b001, 2'b01);
    beat("slv0", 32'h0, 2'b10, 1'b0);
    beat("slv1", 32'h0, 2'b10, 1'b1);

    // Crossing the memory top
    ar(4'd7, MB + 32'hFFC, 8'd1, 3'b010, 2'b01);
    beat("top0", 32'hCAFE_F00D, 2'b00, 1'b0);
    beat("top1", 32'h0, 2'b11, 1'b1);

    // Random backpressure, LEN=15
    ar(4'd9, MB, 8'd15, 3'b010, 2'b01);
    idx = 0;
    cyc = 0;
    while (idx < 16 && cyc < 300) begin
      rr = 1'($urandom_range(0, 1));
      if (S_RVALID) begin
        chk("bp_data", S_RDATA, 32'h100 + 32'(idx));
        chk("bp_resp", {30'd0, S_RRESP}, 32'd0);
        chk("bp_last", {31'd0, S_RLAST}, {31'd0, idx == 15});
        if (rr) idx++;
      end
      S_RREADY = rr;
      tick();
      cyc++;
    end
    if (idx != 16) timeout("bp_beats");
    S_RREADY = 1'b1;
    chk("bp_done", {31'd0, S_RVALID}, 32'd0);

    // Regbus read steals the fetch cycle
    ar(4'd5, MB, 8'd1, 3'b010, 2'b01);
    regrd("cf_rd", 16'h4004, 32'h101);
    chk("cf_slip", {31'd0, S_RVALID}, 32'd0);
    tick();
    chk("cf_valid", {31'd0, S_RVALID}, 32'd1);
    beat("cf0", 32'h100, 2'b00, 1'b0);
    beat("cf1", 32'h101, 2'b00, 1'b1);

    // Write and fetch of the same word: old data, LEN=0
    ar(4'd6, MB, 8'd0, 3'b010, 2'b00);
    regwr(16'h4000, 4'hF, 32'hAAAA_5555);
    beat("rbw", 32'h100, 2'b00, 1'b1);
    regrd("rbw_new", 16'h4000, 32'hAAAA_5555);

    // Reset mid-burst
    S_RREADY = 1'b0;
    ar(4'd8, MB, 8'd15, 3'b010, 2'b01);
    tick();
    tick();
    tick();
    ARESET = 1'b1;
    tick();
    chk("mrst_rvalid", {31'd0, S_RVALID}, 32'd0);
    chk("mrst_arready", {31'd0, S_ARREADY}, 32'd0);
    chk("mrst_rid", {28'd0, S_RID}, 32'd0);
    chk("mrst_regrdata", RDATA, 32'd0);
    ARESET = 1'b0;
    tick();
    chk("mrst_rel_arready", {31'd0, S_ARREADY}, 32'd1);
    chk("mrst_no_beat", {31'd0, S_RVALID}, 32'd0);
    S_RREADY = 1'b1;
    ar(4'd10, MB, 8'd1, 3'b010, 2'b01);
    beat("mrst0", 32'hAAAA_5555, 2'b00, 1'b0);
    beat("mrst1", 32'h101, 2'b00, 1'b1);

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule

// File: doc/axi_imem_slave.md
Name: axi_imem_slave

Overview:
- AXI4 read-only slave that serves instruction fetch from an on-chip word memory. It is the responder end of the ifetch AXI read port.
- It replaces the simulation VIP memory model for standalone and FPGA builds.
- Memory contents are loaded and read back over the existing regbus, through a dedicated window next to the BOOTCTRL registers.
- The block sits between the core's ifetch master and the regbus host.

Parameters:
- MEM_BASE, 32'h2000_0000, AXI byte address of memory word 0.
- DEPTH_WORDS, 1024, number of 32-bit words; must be a power of two, maximum 1024.
- REG_BASE, 16'h4000, regbus byte address of word 0; the window is DEPTH_WORDS*4 bytes.
- ID_W, 4, AXI ID width.

Ports:
- ACLK  in  1  clock.
- ARESET  in  1  reset; synchronous, active-high.
- WRADDR  in  16  regbus write byte address.
- BYTEEN  in  4  regbus write byte enables.
- WREN  in  1  regbus write strobe, one cycle.
- WDATA  in  32  regbus write data.
- RDADDR  in  16  regbus read byte address.
- RDEN  in  1  regbus read strobe, one cycle.
- RDATA  out  32  regbus read data.
- S_ARID  in  ID_W  read ID.
- S_ARADDR  in  32  burst start byte address.
- S_ARLEN  in  8  beats minus one.
- S_ARSIZE  in  3  beat size.
- S_ARBURST  in  2  burst type.
- S_ARVALID  in  1  address valid.
- S_ARREADY  out  1  address ready.
- S_RID  out  ID_W  echoes the captured ARID.
- S_RDATA  out  32  beat data.
- S_RRESP  out  2  beat response.
- S_RLAST  out  1  final beat of the burst.
- S_RVALID  out  1  beat valid.
- S_RREADY  in  1  beat ready.

Behaviour:
- Reset (next edge with ARESET=1):
  - S_ARREADY=0, S_RVALID=0, S_RLAST=0, S_RRESP=0, S_RDATA=0, S_RID=0, RDATA=0.
  - FSM goes to IDLE. An in-flight burst is abandoned; no further beats are sent.
  - Memory contents are not cleared.
- FSM states: IDLE, BURST, DRAIN.
- IDLE:
  - S_ARREADY=1 in every IDLE cycle after reset is released.
  - On ARVALID&&ARREADY: capture ID, address, LEN, SIZE and BURST; set beat counter = LEN; go to BURST.
  - S_ARREADY=0 from the cycle after the handshake.
- Response classification, fixed at AR capture and applied to the whole burst:
  - ARSIZE!=3'b010, ARBURST=2'b11, or WRAP with LEN not in {1,3,7,15} -> SLVERR (2'b10) on every beat.
  - Otherwise, per beat: address outside [MEM_BASE, MEM_BASE+DEPTH_WORDS*4) -> DECERR (2'b11); in range -> OKAY (2'b00).
  - S_RDATA=0 on every SLVERR or DECERR beat.
  - Error bursts still return exactly LEN+1 beats.
- Beat addressing, with address bits [1:0] ignored:
  - FIXED: every beat uses the start address.
  - INCR: +4 per beat, full 32-bit add.
  - WRAP: +4 per beat, wrapping at an aligned boundary of (LEN+1)*4 bytes.
- Latency and throughput:
  - Memory read is synchronous with 1-cycle latency.
  - First S_RVALID is asserted 2 cycles after the AR handshake cycle.
  - With S_RREADY held high and no regbus reads, beats are issued on consecutive cycles.
  - A 2-entry output buffer provides the prefetch, so S_RREADY=0 never loses a beat.
- R channel handshake:
  - While S_RVALID=1 and S_RREADY=0, S_RDATA, S_RRESP, S_RLAST and S_RID are held stable.
  - S_RLAST=1 only on beat LEN.
- Burst end:
  - After the last beat's handshake the FSM goes to DRAIN for one cycle, then IDLE.
  - A new AR is therefore accepted no earlier than 2 cycles after the final R handshake.
- Regbus write:
  - Address hit when WRADDR is in the window.
  - Word index = (WRADDR-REG_BASE)>>2.
  - BYTEEN[i] enables byte lane i. Misses are ignored.
- Regbus read:
  - RDATA is valid in the cycle after the RDEN cycle, and holds until the next RDEN.
  - A miss returns 32'h0.
- Port arbitration:
  - The memory has one write port and one read port.
  - A regbus read has priority on the read port; the AXI beat fetch that cycle slips by one cycle, which only delays S_RVALID.
  - A regbus write and an AXI fetch of the same word in the same cycle: the AXI beat returns the old data (read-before-write).
- LEN=0: single beat with S_RLAST=1.
- LEN=255 INCR crossing the memory top: beats past the top return DECERR; in-range beats return OKAY.

Test Plan:
- Write 0xDEADBEEF to 0x4000, then BYTEEN=4'b0010 with WDATA=0x0000_1100 to 0x4000; read 0x4000 -> RDATA=0xDEAD11EF one cycle after RDEN.
- Load words 0..7 = 0x100+i; INCR AR addr=0x2000_0000, LEN=7, ID=3, RREADY=1 -> first RVALID 2 cycles after handshake; 8 consecutive beats 0x100..0x107, RRESP=0, RID=3, RLAST only on beat 7.
- WRAP AR addr=0x2000_0008, LEN=3 -> data words 2,3,0,1.
- FIXED AR at 0x2000_0004, LEN=2 -> three beats of word 1.
- ARSIZE=3'b001, LEN=1 -> two beats with RRESP=2'b10, RDATA=0.
- INCR AR addr=MEM_BASE+0xFFC, LEN=1 -> beat 0 OKAY, beat 1 DECERR.
- Random RREADY backpressure during a LEN=15 burst -> outputs stable while stalled; all 16 beats correct and in order.
- A regbus read in the same cycle as a beat fetch -> that beat is delayed by one cycle, not lost.
- ARESET pulse mid-burst -> RVALID=0 and ARREADY=0 on the next edge; ARREADY=1 after release; a new burst returns correct data.
